// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer: load/start/pause/mode in, count/status out.
// Latency: n/a (signal bundle only).
// Backpressure: none; all signals are plain levels/pulses.
`timescale 1ns/1ps
interface down_timer_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             done;
  logic             expired;

  // Controller side: drives commands, observes timer status.
  modport master (
    output load, load_val, start, pause, auto_reload,
    input  count, running, done, expired
  );

  // Timer side: consumes commands, drives status.
  modport slave (
    input  load, load_val, start, pause, auto_reload,
    output count, running, done, expired
  );
endinterface

// File: rtl/down_timer.sv
// Loadable, prescaled down-counter: decrements every TICK_DIV cycles, pulses done at expiry.
// Latency: all outputs registered; first decrement TICK_DIV cycles after entering RUN.
// Backpressure: none; commands act in the cycle they are sampled (load > pause > start).
`timescale 1ns/1ps
module down_timer #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic         clk50m,
  input  logic         rst_n,
  down_timer_if.slave  bus
);

  // Prescaler is at least one bit wide so TICK_DIV == 1 still elaborates;
  // in that case it sits at 0 and every RUN cycle is a tick.
  localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] w_reload_nxt;
  logic [PW-1:0]    r_pre;
  logic [PW-1:0]    w_pre_nxt;
  logic             r_expired;
  logic             w_expired_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_running;
  logic             w_running_nxt;

  logic             w_count_zero;
  logic             w_reload_zero;
  logic             w_tick;
  logic             w_advance;
  logic             w_expiry;

  assign w_count_zero  = (r_count == '0);
  assign w_reload_zero = (r_reload == '0);
  assign w_tick        = (r_pre == PRE_MAX);
  // Counting proceeds only in RUN with no higher-priority command this cycle.
  assign w_advance     = (r_state == S_RUN) && !bus.load && !bus.pause;
  assign w_expiry      = w_advance && w_tick && (r_count == WIDTH'(1));

  // State register.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath next values, honouring load > pause > start.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_reload_nxt  = r_reload;
    w_pre_nxt     = r_pre;
    w_expired_nxt = r_expired;
    if (bus.load) begin
      w_count_nxt   = bus.load_val;
      w_reload_nxt  = bus.load_val;
      w_pre_nxt     = '0;
      w_expired_nxt = 1'b0;
      w_state_nxt   = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_PAUSED: begin
          // A zero count has nothing to time, so start is ignored.
          if (!bus.pause && bus.start && !w_count_zero) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (bus.pause) begin
            w_state_nxt = S_PAUSED;
          end else if (w_tick) begin
            w_pre_nxt = '0;
            if (r_count > WIDTH'(1)) begin
              w_count_nxt = r_count - WIDTH'(1);
            end else if (r_count == WIDTH'(1)) begin
              // auto_reload is only consulted here, at the moment of expiry.
              if (bus.auto_reload && !w_reload_zero) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt   = '0;
                w_expired_nxt = 1'b1;
                w_state_nxt   = S_EXPIRED;
              end
            end
          end else begin
            w_pre_nxt = r_pre + PW'(1);
          end
        end
        S_EXPIRED: begin
          if (!bus.pause && bus.start) begin
            w_count_nxt   = r_reload;
            w_expired_nxt = 1'b0;
            w_pre_nxt     = '0;
            w_state_nxt   = w_reload_zero ? S_IDLE : S_RUN;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state, so registered outputs line up with the state.
  always_comb begin
    w_running_nxt = (w_state_nxt == S_RUN);
    w_done_nxt    = w_expiry;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_reload  <= '0;
      r_pre     <= '0;
      r_expired <= 1'b0;
      r_done    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_reload  <= w_reload_nxt;
      r_pre     <= w_pre_nxt;
      r_expired <= w_expired_nxt;
      r_done    <= w_done_nxt;
      r_running <= w_running_nxt;
    end
  end

  assign bus.count   = r_count;
  assign bus.running = r_running;
  assign bus.done    = r_done;
  assign bus.expired = r_expired;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer with TICK_DIV=4: expectations queued per cycle, checked after the edge.
// Latency: one expectation entry consumed per clock.
// Backpressure: none.
`timescale 1ns/1ps
module tb_down_timer;

  logic clk50m = 1'b0;
  logic rst_n;

  always #10 clk50m = ~clk50m;

  down_timer_if #(.WIDTH(8)) bus ();

  down_timer #(
    .WIDTH   (8),
    .TICK_DIV(4)
  ) dut (
    .clk50m(clk50m),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] cnt;
    logic       run;
    logic       dn;
    logic       ex;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input int c, input logic r, input logic d, input logic e);
    exp_t x;
    x.tag = tag;
    x.cnt = 8'(c);
    x.run = r;
    x.dn  = d;
    x.ex  = e;
    sb.push_back(x);
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed=0 entries expected>=1");
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".count"},   bus.count,   x.cnt);
      chk({x.tag, ".running"}, bus.running, {7'd0, x.run});
      chk({x.tag, ".done"},    bus.done,    {7'd0, x.dn});
      chk({x.tag, ".expired"}, bus.expired, {7'd0, x.ex});
    end
  endtask

  // One clock with the currently driven inputs; outputs checked on the falling edge,
  // then the pulse-style commands are dropped.
  task automatic cyc(input string tag, input int c, input logic r, input logic d, input logic e);
    push(tag, c, r, d, e);
    @(posedge clk50m);
    @(negedge clk50m);
    pop_check();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.load        = 1'b0;
    bus.load_val    = 8'd0;
    bus.start       = 1'b0;
    bus.pause       = 1'b0;
    bus.auto_reload = 1'b0;

    #5;
    push("reset", 0, 1'b0, 1'b0, 1'b0);
    pop_check();
    @(negedge clk50m);
    @(negedge clk50m);
    rst_n = 1'b1;

    // Start with a zero count is ignored; load wins over a concurrent start.
    bus.start = 1'b1;
    cyc("t4_start_zero", 0, 1'b0, 1'b0, 1'b0);
    bus.load = 1'b1; bus.load_val = 8'd7; bus.start = 1'b1;
    cyc("t4_load_start", 7, 1'b0, 1'b0, 1'b0);
    cyc("t4_idle_hold", 7, 1'b0, 1'b0, 1'b0);

    // One-shot from 3: decrements at +4,+8, expiry at +12, then held.
    bus.load = 1'b1; bus.load_val = 8'd3;
    cyc("t1_load", 3, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc("t1_start", 3, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k < 12) cyc("t1_run", 3 - k / 4, 1'b1, 1'b0, 1'b0);
      else        cyc("t1_expire", 0, 1'b0, 1'b1, 1'b1);
    end
    for (int k = 0; k < 20; k++) cyc("t1_hold", 0, 1'b0, 1'b0, 1'b1);

    // One-shot from 2, then restart from EXPIRED reloads and expires again at +8.
    bus.load = 1'b1; bus.load_val = 8'd2;
    cyc("t6_load", 2, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc("t6_start", 2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) cyc("t6_run", 2 - k / 4, 1'b1, 1'b0, 1'b0);
      else       cyc("t6_expire", 0, 1'b0, 1'b1, 1'b1);
    end
    bus.start = 1'b1;
    cyc("t6_restart", 2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) cyc("t6_rerun", 2 - k / 4, 1'b1, 1'b0, 1'b0);
      else       cyc("t6_reexpire", 0, 1'b0, 1'b1, 1'b1);
    end
    cyc("t6_hold", 0, 1'b0, 1'b0, 1'b1);

    // Periodic from 2: 2,1,2,1 with done every 8 cycles, running never drops.
    bus.auto_reload = 1'b1;
    bus.load = 1'b1; bus.load_val = 8'd2;
    cyc("t2_load", 2, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc("t2_start", 2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      cyc("t2_period", (((k / 4) % 2) == 0) ? 2 : 1, 1'b1, ((k % 8) == 0), 1'b0);
    end
    bus.auto_reload = 1'b0;

    // Pause with prescaler at 2; resume decrements two cycles later.
    bus.load = 1'b1; bus.load_val = 8'd5;
    cyc("t3_load", 5, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc("t3_start", 5, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) cyc("t3_run", 5 - k / 4, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      bus.pause = 1'b1;
      cyc("t3_paused", 4, 1'b0, 1'b0, 1'b0);
    end
    bus.start = 1'b1;
    cyc("t3_resume", 4, 1'b1, 1'b0, 1'b0);
    cyc("t3_resume_p3", 4, 1'b1, 1'b0, 1'b0);
    cyc("t3_resume_dec", 3, 1'b1, 1'b0, 1'b0);

    // Reset mid-run clears everything immediately, with no done pulse.
    bus.load = 1'b1; bus.load_val = 8'd5;
    cyc("t5_load", 5, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc("t5_start", 5, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) cyc("t5_run", 5 - k / 4, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    push("t5_async", 0, 1'b0, 1'b0, 1'b0);
    pop_check();
    for (int k = 0; k < 6; k++) cyc("t5_in_reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc("t5_idle", 0, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    cyc("t5_start_ignored", 0, 1'b0, 1'b0, 1'b0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
